parity_generator: RTL and testbench

// - Registered even/odd parity generator for a DATA_W-bit word (default 3 bits).
// - Computes both parity bits from data_in.
// - Outputs them one clock later, aligned with a registered copy of the data and a valid flag.
// - Sits on the TX side of a link, ahead of the serializer; parity_even/parity_odd are appended to the word downstream.
//

---
 rtl/parity_pkg.sv | 18 +
 rtl/parity_tree.sv | 36 +++
 rtl/parity_generator.sv | 53 +++++
 tb/tb_parity_generator.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared parity definitions: mode constants that select the polarity of the
// appended parity bit, plus a reference XOR reduction over the low w bits.
package parity_pkg;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;
  localparam int   MAX_W       = 64;

  function automatic logic parity_f(logic [MAX_W-1:0] d, int w);
    logic p;
    p = 1'b0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w) p = p ^ d[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/parity_tree.sv
// Purely combinational balanced XOR reduction of a DATA_W-bit word.
// Leaves are zero-padded up to a power of two, then halved level by level.
module parity_tree #(
  parameter int DATA_W = 3
) (
  input  logic [DATA_W-1:0] data,
  output logic              parity
);

  localparam int LEVELS = (DATA_W > 1) ? $clog2(DATA_W) : 0;
  localparam int LEAVES = 1 << LEVELS;

  genvar gi, gj;
  generate
    for (gi = 0; gi <= LEVELS; gi++) begin : g_lvl
      localparam int W = LEAVES >> gi;
      logic [W-1:0] v;
      if (gi == 0) begin : g_leaf
        for (gj = 0; gj < W; gj++) begin : g_bit
          if (gj < DATA_W) begin : g_used
            assign v[gj] = data[gj];
          end else begin : g_pad
            assign v[gj] = 1'b0;
          end
        end
      end else begin : g_node
        for (gj = 0; gj < W; gj++) begin : g_bit
          assign v[gj] = g_lvl[gi-1].v[2*gj] ^ g_lvl[gi-1].v[2*gj+1];
        end
      end
    end
  endgenerate

  assign parity = g_lvl[LEVELS].v[0];

endmodule

// File: rtl/parity_generator.sv
// Registered even/odd parity generator: one-cycle latency, word, both parity
// bits and a valid flag all come straight from flops.
module parity_generator
  import parity_pkg::*;
#(
  parameter int DATA_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              in_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              parity_even,
  output logic              parity_odd,
  output logic              out_valid
);

  logic              tree_par;
  logic [DATA_W-1:0] data_reg;
  logic              even_reg;
  logic              odd_reg;
  logic              valid_reg;

  parity_tree #(
    .DATA_W (DATA_W)
  ) u_tree (
    .data   (data_in),
    .parity (tree_par)
  );

  // Reset values describe the all-zero word, so odd parity resets to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg  <= '0;
      even_reg  <= PARITY_EVEN;
      odd_reg   <= PARITY_ODD;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= in_valid;
      if (in_valid) begin
        data_reg <= data_in;
        even_reg <= tree_par ^ PARITY_EVEN;
        odd_reg  <= tree_par ^ PARITY_ODD;
      end
    end
  end

  assign data_out    = data_reg;
  assign parity_even = even_reg;
  assign parity_odd  = odd_reg;
  assign out_valid   = valid_reg;

endmodule

// File: tb/tb_parity_generator.sv
// Bench for parity_generator (DATA_W=3 and DATA_W=8) against a ones-count
// model, with literal spot checks that pin the model.
module tb_parity_generator;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic [2:0] data_in  = 3'b111;
  logic       in_valid = 1'b1;
  logic [2:0] data_out;
  logic       parity_even, parity_odd, out_valid;

  logic [7:0] data8_in  = 8'h00;
  logic       valid8_in = 1'b0;
  logic [7:0] data8_out;
  logic       even8, odd8, valid8_out;

  int n_checks = 0;
  int n_fail   = 0;
  bit run_cmp  = 1'b1;

  // Model state: the last accepted word and whether the previous edge accepted one.
  logic [2:0] m_data   = 3'b000;
  logic       m_valid  = 1'b0;
  logic [7:0] m_data8  = 8'h00;
  logic       m_valid8 = 1'b0;

  parity_generator #(.DATA_W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .in_valid    (in_valid),
    .data_out    (data_out),
    .parity_even (parity_even),
    .parity_odd  (parity_odd),
    .out_valid   (out_valid)
  );

  parity_generator #(.DATA_W(8)) dut8 (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data8_in),
    .in_valid    (valid8_in),
    .data_out    (data8_out),
    .parity_even (even8),
    .parity_odd  (odd8),
    .out_valid   (valid8_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data   = '0;
      m_valid  = 1'b0;
      m_data8  = '0;
      m_valid8 = 1'b0;
    end else begin
      m_valid = in_valid;
      if (in_valid) m_data = data_in;
      m_valid8 = valid8_in;
      if (valid8_in) m_data8 = data8_in;
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      check("model_data",   {61'd0, data_out}, {61'd0, m_data});
      check("model_even",   {63'd0, parity_even}, 64'($countones(m_data) % 2));
      check("model_odd",    {63'd0, parity_odd},  64'(1 - ($countones(m_data) % 2)));
      check("model_valid",  {63'd0, out_valid}, {63'd0, m_valid});
      check("invariant",    {63'd0, parity_odd}, {63'd0, ~parity_even});
      check("model8_data",  {56'd0, data8_out}, {56'd0, m_data8});
      check("model8_even",  {63'd0, even8}, 64'($countones(m_data8) % 2));
      check("model8_valid", {63'd0, valid8_out}, {63'd0, m_valid8});
      check("invariant8",   {63'd0, odd8}, {63'd0, ~even8});
    end
  end

  initial begin
    logic [7:0] even_tbl;
    even_tbl = 8'b1001_0110;   // bit v = expected parity_even of word v

    // Reset held with active-looking inputs.
    repeat (2) @(posedge clk);
    #1;
    check("rst_data",  {61'd0, data_out}, 64'd0);
    check("rst_even",  {63'd0, parity_even}, 64'd0);
    check("rst_odd",   {63'd0, parity_odd}, 64'd1);
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;

    // Exhaustive sweep, back to back.
    @(posedge clk); #2;
    in_valid = 1'b1;
    data_in  = 3'd0;
    for (int v = 0; v < 8; v++) begin
      @(posedge clk); #1;
      check("sweep_even",  {63'd0, parity_even}, {63'd0, even_tbl[v]});
      check("sweep_odd",   {63'd0, parity_odd}, {63'd0, ~even_tbl[v]});
      check("sweep_valid", {63'd0, out_valid}, 64'd1);
      #1;
      if (v < 7) data_in = 3'(v + 1);
    end

    // Hold: an idle cycle keeps the word and parity, drops valid.
    data_in = 3'b011;
    @(posedge clk); #1;
    #1;
    in_valid = 1'b0;
    data_in  = 3'b001;
    @(posedge clk); #1;
    check("hold_data",  {61'd0, data_out}, 64'd3);
    check("hold_even",  {63'd0, parity_even}, 64'd0);
    check("hold_valid", {63'd0, out_valid}, 64'd0);

    // Async reset between edges after accepting 101.
    #1;
    in_valid = 1'b1;
    data_in  = 3'b101;
    @(posedge clk); #1;
    check("pre_rst_data", {61'd0, data_out}, 64'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_data",  {61'd0, data_out}, 64'd0);
    check("async_even",  {63'd0, parity_even}, 64'd0);
    check("async_odd",   {63'd0, parity_odd}, 64'd1);
    check("async_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #2;
    rst_n    = 1'b1;
    in_valid = 1'b0;

    // Wide variant literals.
    @(posedge clk); #2;
    valid8_in = 1'b1;
    data8_in  = 8'hFF;
    @(posedge clk); #1;
    check("w8_ff_even", {63'd0, even8}, 64'd0);
    #1;
    data8_in = 8'h01;
    @(posedge clk); #1;
    check("w8_01_even", {63'd0, even8}, 64'd1);
    check("w8_01_odd",  {63'd0, odd8}, 64'd0);
    #1;
    valid8_in = 1'b0;

    // Random stream on both instances.
    for (int c = 0; c < 1000; c++) begin
      @(posedge clk); #2;
      data_in   = 3'($urandom);
      in_valid  = 1'($urandom % 2);
      data8_in  = 8'($urandom);
      valid8_in = 1'($urandom % 2);
    end
    @(posedge clk); #2;
    in_valid  = 1'b0;
    valid8_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    run_cmp = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
